idma_rd_fifo_unpack: RTL and testbench
======================================

// Module: idma_rd_fifo_unpack
// PURPOSE
//  Downstream consumer of the iDMA read-sync SRAM FIFO. Pops FIFO_WIDTH words from the FIFO's
//  registered output stage and serialises each into OUT_WIDTH beats on a valid/ready stream.
//  A programmed beat count controls the transfer. The block terminates the transfer with
//  out_last and a done pulse.
//  It sits between the read-sync FIFO and the narrow-side write/NoC packetiser.
// PARAMETERS
//  IN_WIDTH   128  FIFO word width; must equal the FIFO's FIFO_WIDTH
//  OUT_WIDTH  32   output beat width; IN_WIDTH must be an integer multiple of it
//  RATIO      IN_WIDTH/OUT_WIDTH  beats per FIFO word (localparam, >=2)
//  LEN_WID    16   width of the transfer beat counter
// PORTS
//  clk           in   1         clock
//  rst_n         in   1         asynchronous active-low reset
//  cfg_start     in   1         1-cycle pulse: start a transfer (ignored while busy)
//  cfg_len       in   LEN_WID   output beats in the transfer; sampled with cfg_start
//  cfg_abort     in   1         synchronous abort: return to IDLE, no done pulse
//  fifo_empty    in   1         FIFO output stage holds no valid word
//  fifo_data_in  in   IN_WIDTH  FIFO output word (fifo_data_out of FIFO)
//  fifo_pop      out  1         consume FIFO head this cycle (only when !fifo_empty)
//  out_valid     out  1         out_data valid
//  out_data      out  OUT_WIDTH current beat
//  out_last      out  1         final beat of transfer (qualified by out_valid)
//  out_ready     in   1         downstream accepts beat
//  busy          out  1         transfer in progress (state != IDLE)
//  done          out  1         1-cycle pulse after the last beat handshakes
// BEHAVIOUR
//  Reset: state=IDLE, fifo_pop=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0,
//   remain=0, idx=0, word buffer=0.
//  FSM states: IDLE, LOAD, SEND.
//  IDLE:
//   - cfg_start & cfg_len!=0 -> remain<=cfg_len, idx<=0, go LOAD.
//   - cfg_start & cfg_len==0 -> done=1 next cycle, stay IDLE.
//  LOAD: fifo_pop = !fifo_empty (combinational). On pop, the word is captured into the buffer
//   and the FSM goes SEND. out_valid=0 in LOAD.
//  SEND: out_valid=1, out_data = buf[idx*OUT_WIDTH +: OUT_WIDTH], LSB slice first.
//   out_last = (remain==1).
//  SEND, on out_valid & out_ready:
//   - remain==1: go IDLE, done=1 next cycle. Unsent slices of the current word are discarded;
//     no extra pop.
//   - idx==RATIO-1 & !fifo_empty: pop and reload the buffer in the same cycle, idx<=0, stay
//     SEND. There is no bubble; sustained throughput is 1 beat/cycle.
//   - idx==RATIO-1 & fifo_empty: go LOAD (bubble until data arrives).
//   - otherwise: idx<=idx+1.
//   - Every handshake does remain<=remain-1.
//  Stall: with out_ready=0, out_data/out_last hold stable and out_valid stays 1 (AXI-stream
//   rule). fifo_pop=0.
//  fifo_pop is never asserted when fifo_empty=1, and never outside LOAD/reload-in-SEND.
//   Any FIFO word is popped at most once.
//  cfg_abort (priority over all but reset): next cycle state=IDLE, out_valid=0, remain=0,
//   no done. A pop coinciding with abort still consumes the word. cfg_start in the abort
//   cycle is ignored.
//  cfg_start while busy is ignored; the transfer in progress is unaffected.
//  remain is an LEN_WID-bit down-counter. Max transfer is 2^LEN_WID-1 beats; no wrap, because
//   the FSM exits at remain==1.
//  Async reset mid-transfer: all state cleared immediately; FIFO contents are not touched
//   (the owner issues fifo_init).
// TESTING
//  1. cfg_len=8, RATIO=4, FIFO preloaded with 2 words, out_ready=1 -> 8 beats on consecutive
//     cycles, LSB slice first; out_last on beat 8; exactly 2 pops; done 1 cycle after beat 8.
//  2. cfg_len=6, 2 words -> 6 beats; last 2 slices of word 2 dropped; 2 pops; FIFO left empty.
//  3. cfg_len=4, word arrives 5 cycles after start -> stays LOAD with fifo_pop=0, then 4 beats.
//  4. Random out_ready (50%) over cfg_len=100 -> out_data stable during stalls; beat order
//     matches the word stream; 25 pops total.
//  5. cfg_abort at beat 3 of cfg_len=16 -> out_valid=0 next cycle, busy=0, no done. A new
//     cfg_start then behaves as from reset.
//  6. cfg_len=0 -> done pulse, no pop, no out_valid. cfg_start while busy -> ignored.
//     rst_n low mid-SEND -> all outputs 0 immediately.

Source files
------------

// File: rtl/idma_rd_fifo_unpack.sv
// Pops wide words from the iDMA read-sync FIFO output stage and serialises them,
// LSB slice first, into a programmed number of narrow valid/ready beats.
module idma_rd_fifo_unpack #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 32,
  parameter int LEN_WID   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic [LEN_WID-1:0]   cfg_len,
  input  logic                 cfg_abort,
  input  logic                 fifo_empty,
  input  logic [IN_WIDTH-1:0]  fifo_data_in,
  output logic                 fifo_pop,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [LEN_WID-1:0]             remain_q, remain_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [IN_WIDTH-1:0]            word_q, word_d;
  logic                           done_q, done_d;
  logic [RATIO-1:0][OUT_WIDTH-1:0] slices;
  logic                           hs;
  logic                           last_beat;
  logic                           idx_end;

  // Handshake: a beat transfers on any cycle where out_valid and out_ready are both high;
  // while out_ready is low, out_valid, out_data and out_last hold unchanged.
  assign slices    = word_q;
  assign hs        = (state_q == SEND) && out_ready;
  assign last_beat = (remain_q == LEN_WID'(1));
  assign idx_end   = (idx_q == IDX_W'(RATIO - 1));

  assign out_valid = (state_q == SEND);
  assign out_data  = slices[idx_q];
  assign out_last  = (state_q == SEND) && last_beat;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    idx_d    = idx_q;
    word_d   = word_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_len != '0) begin
            remain_d = cfg_len;
            idx_d    = '0;
            state_d  = LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          word_d   = fifo_data_in;
          idx_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          remain_d = remain_q - LEN_WID'(1);
          if (last_beat) begin
            // Remaining slices of the current word are dropped on purpose.
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (idx_end) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              word_d   = fifo_data_in;
              idx_d    = '0;
            end else begin
              state_d = LOAD;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything; a pop issued this cycle still consumes its word.
    if (cfg_abort) begin
      state_d  = IDLE;
      remain_d = '0;
      idx_d    = '0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      remain_q <= '0;
      idx_q    <= '0;
      word_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_idma_rd_fifo_unpack.sv
// Directed-plus-random bench for idma_rd_fifo_unpack: a queue-based FIFO model feeds the
// DUT and the expected beat stream is derived from the words and the beat count alone.
module tb_idma_rd_fifo_unpack;
  localparam int IN_WIDTH  = 128;
  localparam int OUT_WIDTH = 32;
  localparam int LEN_WID   = 16;
  localparam int RATIO     = IN_WIDTH / OUT_WIDTH;
  localparam int W         = OUT_WIDTH + 1;
  localparam int BUDGET    = 2000;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 cfg_start = 1'b0;
  logic [LEN_WID-1:0]   cfg_len = '0;
  logic                 cfg_abort = 1'b0;
  logic                 fifo_empty = 1'b1;
  logic [IN_WIDTH-1:0]  fifo_data_in = '0;
  logic                 out_ready = 1'b0;
  logic                 fifo_pop, out_valid, out_last, busy, done;
  logic [OUT_WIDTH-1:0] out_data;
  logic [1:0]           state_dbg;

  always #5 clk = ~clk;

  idma_rd_fifo_unpack #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .LEN_WID  (LEN_WID)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_start   (cfg_start),
    .cfg_len     (cfg_len),
    .cfg_abort   (cfg_abort),
    .fifo_empty  (fifo_empty),
    .fifo_data_in(fifo_data_in),
    .fifo_pop    (fifo_pop),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // Scoreboard: {last, data} for every beat still owed by the current transfer.
  logic [IN_WIDTH-1:0] fq[$];
  logic [IN_WIDTH-1:0] pending[$];
  logic [W-1:0]        exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   pops = 0;
  int   hs_cnt = 0;
  int   hold_cycles = 0;
  int   trickle_pct = 100;
  logic done_exp = 1'b0;
  logic zero_start = 1'b0;
  logic prev_stall = 1'b0;

  task automatic check(input string tag, input logic [IN_WIDTH-1:0] obs,
                       input logic [IN_WIDTH-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void fifo_sync();
    fifo_empty   = (fq.size() == 0);
    fifo_data_in = (fq.size() != 0) ? fq[0] : '0;
  endfunction

  // One clock cycle: inputs already driven at the falling edge, outputs checked just after it.
  task automatic tick();
    logic p, hs;
    logic [W-1:0] e;
    e = '0;
    #1;
    p  = fifo_pop;
    hs = out_valid && out_ready && !cfg_abort;
    if (fifo_empty) check("pop_when_empty", fifo_pop, 1'b0);
    check("done", done, done_exp);
    if (prev_stall) check("valid_hold", out_valid, 1'b1);
    if (out_valid) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_beat: observed data %0h expected no beat", out_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("beat", {out_last, out_data}, e);
        if (hs) void'(exp_q.pop_front());
      end
    end
    done_exp   = (hs && e[W-1]) || zero_start;
    prev_stall = out_valid && !out_ready && !cfg_abort;
    if (hs) hs_cnt++;
    @(posedge clk);
    #1;
    if (p && fq.size() != 0) void'(fq.pop_front());
    if (p) pops++;
    if (pending.size() != 0) begin
      if (hold_cycles > 0) hold_cycles--;
      else if ($urandom_range(0, 99) < trickle_pct) fq.push_back(pending.pop_front());
    end
    fifo_sync();
    @(negedge clk);
  endtask

  // Plans random words for a transfer of len beats; returns the number of words it needs.
  function automatic int plan(input int len);
    int nw;
    logic [IN_WIDTH-1:0] w;
    nw = (len + RATIO - 1) / RATIO;
    for (int k = 0; k < nw; k++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      pending.push_back(w);
      for (int s = 0; s < RATIO; s++)
        if (k * RATIO + s < len)
          exp_q.push_back({(k * RATIO + s == len - 1), w[s*OUT_WIDTH +: OUT_WIDTH]});
    end
    return nw;
  endfunction

  task automatic run_transfer(input int len, input int ready_pct, input bit preload,
                              input int hold, input int trickle, input int abort_beat,
                              input int busy_start_beat, output int cycles);
    int nw, pops0, hs0;
    bit aborted;
    nw = plan(len);
    pops0 = pops;
    hs0 = hs_cnt;
    hold_cycles = hold;
    trickle_pct = trickle;
    aborted = 1'b0;
    if (preload) while (pending.size() != 0) fq.push_back(pending.pop_front());
    fifo_sync();
    cfg_len = LEN_WID'(len);
    cfg_start = 1'b1;
    out_ready = 1'b0;
    tick();
    cfg_start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < BUDGET && !aborted) begin
      out_ready = ($urandom_range(0, 99) < ready_pct);
      cfg_abort = (abort_beat != 0) && out_valid && (hs_cnt - hs0 == abort_beat - 1);
      if (busy_start_beat != 0 && hs_cnt - hs0 == busy_start_beat) begin
        cfg_start = 1'b1;
        cfg_len = LEN_WID'(3);
      end
      aborted = cfg_abort;
      tick();
      cycles++;
      cfg_abort = 1'b0;
      cfg_start = 1'b0;
    end
    check("timeout", cycles < BUDGET, 1'b1);
    if (aborted) begin
      check("abort_valid", out_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      exp_q.delete();
      pending.delete();
      fq.delete();
      fifo_sync();
    end else begin
      tick();
      check("pops", pops - pops0, nw);
      check("idle_after", busy, 1'b0);
      check("valid_after", out_valid, 1'b0);
      check("done_low", done, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, pops0, len, rdy;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_data", out_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pop", fifo_pop, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two preloaded words, full throughput: LOAD cycle then 8 back-to-back beats
    run_transfer(8, 100, 1'b1, 0, 100, 0, 0, cyc);
    check("t1_cycles", cyc, 9);

    // Short transfer drops the tail of the second word and leaves the FIFO empty
    run_transfer(6, 100, 1'b1, 0, 100, 0, 0, cyc);
    check("t2_fifo_empty", fq.size(), 0);

    // Word arrives late: DUT waits in LOAD without popping
    run_transfer(4, 100, 1'b0, 5, 100, 0, 0, cyc);
    check("t3_cycles_min", cyc >= 9, 1'b1);

    // Random backpressure and random word arrival over a long transfer
    run_transfer(100, 50, 1'b0, 0, 50, 0, 0, cyc);

    // Abort on the third beat, then a fresh transfer
    run_transfer(16, 100, 1'b1, 0, 100, 3, 0, cyc);
    run_transfer(5, 70, 1'b1, 0, 100, 0, 0, cyc);

    // Zero-length start: done pulse only
    pops0 = pops;
    cfg_len = '0;
    cfg_start = 1'b1;
    zero_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    zero_start = 1'b0;
    tick();
    tick();
    check("zero_pops", pops - pops0, 0);
    check("zero_busy", busy, 1'b0);

    // Start pulses while busy must not disturb the running transfer
    run_transfer(8, 100, 1'b1, 0, 100, 0, 2, cyc);

    // A few random transfers
    for (int t = 0; t < 4; t++) begin
      len = $urandom_range(1, 40);
      rdy = $urandom_range(30, 100);
      run_transfer(len, rdy, 1'b0, 0, 60, 0, 0, cyc);
    end

    // Asynchronous reset while stalled in SEND
    void'(plan(8));
    while (pending.size() != 0) fq.push_back(pending.pop_front());
    fifo_sync();
    cfg_len = LEN_WID'(8);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("pre_rst_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_last", out_last, 1'b0);
    check("arst_data", out_data, '0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_state", state_dbg, 2'd0);
    exp_q.delete();
    pending.delete();
    fq.delete();
    fifo_sync();
    check("arst_pop", fifo_pop, 1'b0);
    prev_stall = 1'b0;
    done_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_transfer(7, 80, 1'b1, 0, 100, 0, 0, cyc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
